// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ctrl
// Brief    : Alarm controller fed by the clock core. Holds the alarm time,
//            rings on a fresh hour:minute match, handles stop, snooze and an
//            automatic ring timeout. Optional macro ALARM_BLINK_EN gates the
//            ring output with a once-per-second blink flop.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_ctrl #(
    parameter int P_SEC_BIT    = 6,
    parameter int P_MIN_BIT    = 6,
    parameter int P_HOUR_BIT   = 5,
    parameter int P_RING_SEC   = 60,
    parameter int P_SNOOZE_SEC = 300
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  i_one_sec_tick,
    input  logic [P_SEC_BIT-1:0]  sec,
    input  logic [P_MIN_BIT-1:0]  min,
    input  logic [P_HOUR_BIT-1:0] hour,
    input  logic                  i_alarm_set,
    input  logic [P_MIN_BIT-1:0]  i_set_min,
    input  logic [P_HOUR_BIT-1:0] i_set_hour,
    input  logic                  i_alarm_on,
    input  logic                  i_stop,
    input  logic                  i_snooze,
    output logic                  o_ring,
    output logic [1:0]            o_state,
    output logic [P_MIN_BIT-1:0]  o_alarm_min,
    output logic [P_HOUR_BIT-1:0] o_alarm_hour
);

    localparam int RING_W = $clog2(P_RING_SEC) + 1;
    localparam int SNZ_W  = $clog2(P_SNOOZE_SEC + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ARMED  = 2'd1;
    localparam logic [1:0] c_ST_RING   = 2'd2;
    localparam logic [1:0] c_ST_SNOOZE = 2'd3;

    localparam logic [RING_W-1:0]     c_RING_LAST = RING_W'(P_RING_SEC - 1);
    localparam logic [RING_W-1:0]     c_RING_ONE  = RING_W'(1);
    localparam logic [SNZ_W-1:0]      c_SNZ_LOAD  = SNZ_W'(P_SNOOZE_SEC);
    localparam logic [SNZ_W-1:0]      c_SNZ_ONE   = SNZ_W'(1);
    localparam logic [P_HOUR_BIT-1:0] c_HOUR_LIM  = P_HOUR_BIT'(24);
    localparam logic [P_MIN_BIT-1:0]  c_MIN_LIM   = P_MIN_BIT'(60);

    logic [1:0]            r_state;
    logic [RING_W-1:0]     r_ring_cnt;
    logic [SNZ_W-1:0]      r_snz_cnt;
    logic                  r_match_d;
    logic [P_MIN_BIT-1:0]  r_alarm_min;
    logic [P_HOUR_BIT-1:0] r_alarm_hour;

    logic [1:0]            w_nxt_state;
    logic [RING_W-1:0]     w_nxt_ring_cnt;
    logic [SNZ_W-1:0]      w_nxt_snz_cnt;
    logic                  w_match;
    logic                  w_rise;
    logic                  w_load;
    logic                  w_unused_sec;

    // Seconds do not take part in the match; the alarm fires on the minute.
    assign w_unused_sec = ^sec;

    assign w_match = (hour == r_alarm_hour) && (min == r_alarm_min);
    assign w_rise  = w_match && !r_match_d;
    assign w_load  = i_alarm_set && (i_set_hour < c_HOUR_LIM) && (i_set_min < c_MIN_LIM);

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_ring_cnt = r_ring_cnt;
        w_nxt_snz_cnt  = r_snz_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (i_alarm_on) w_nxt_state = c_ST_ARMED;
            end
            c_ST_ARMED: begin
                if (!i_alarm_on) begin
                    w_nxt_state = c_ST_IDLE;
                end else if (w_rise) begin
                    w_nxt_state    = c_ST_RING;
                    w_nxt_ring_cnt = '0;
                end
            end
            c_ST_RING: begin
                if (!i_alarm_on) begin
                    w_nxt_state = c_ST_IDLE;
                end else if (i_stop) begin
                    w_nxt_state = c_ST_ARMED;
                end else if (i_snooze) begin
                    w_nxt_state   = c_ST_SNOOZE;
                    w_nxt_snz_cnt = c_SNZ_LOAD;
                end else if (i_one_sec_tick) begin
                    if (r_ring_cnt == c_RING_LAST) w_nxt_state = c_ST_ARMED;
                    else                           w_nxt_ring_cnt = r_ring_cnt + c_RING_ONE;
                end
            end
            default: begin
                if (!i_alarm_on) begin
                    w_nxt_state = c_ST_IDLE;
                end else if (i_stop) begin
                    w_nxt_state = c_ST_ARMED;
                end else if (i_one_sec_tick) begin
                    if (r_snz_cnt == c_SNZ_ONE) begin
                        w_nxt_state    = c_ST_RING;
                        w_nxt_ring_cnt = '0;
                    end else begin
                        w_nxt_snz_cnt = r_snz_cnt - c_SNZ_ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_ring_cnt   <= '0;
            r_snz_cnt    <= '0;
            r_match_d    <= 1'b0;
            r_alarm_min  <= '0;
            r_alarm_hour <= '0;
        end else if (en) begin
            r_state    <= w_nxt_state;
            r_ring_cnt <= w_nxt_ring_cnt;
            r_snz_cnt  <= w_nxt_snz_cnt;
            r_match_d  <= w_match;
            if (w_load) begin
                r_alarm_min  <= i_set_min;
                r_alarm_hour <= i_set_hour;
            end
        end
    end

`ifdef ALARM_BLINK_EN
    logic r_blink;

    // Starts lit on every entry to ringing, flips once per second while it lasts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink <= 1'b0;
        end else if (en) begin
            if (w_nxt_state != c_ST_RING)   r_blink <= 1'b0;
            else if (r_state != c_ST_RING)  r_blink <= 1'b1;
            else if (i_one_sec_tick)        r_blink <= ~r_blink;
        end
    end

    assign o_ring = (r_state == c_ST_RING) && r_blink;
`else
    assign o_ring = (r_state == c_ST_RING);
`endif

    assign o_state      = r_state;
    assign o_alarm_min  = r_alarm_min;
    assign o_alarm_hour = r_alarm_hour;

endmodule
`default_nettype wire

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Alarm controller sitting directly downstream of the clock core; consumes its sec/min/hour outputs and the one-second tick.
- Holds a programmable alarm time and arms/disarms on a level input.
- Rings on a time match, supports stop, snooze and an automatic ring timeout.
- Drives a ring output toward the buzzer/LED stage.

Parameters:
P_SEC_BIT, 6, width of sec input
P_MIN_BIT, 6, width of min input and alarm minute register
P_HOUR_BIT, 5, width of hour input and alarm hour register
P_RING_SEC, 60, seconds of ringing before automatic timeout (>=1)
P_SNOOZE_SEC, 300, snooze duration in seconds (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
en  input  1  global enable; 0 freezes all registers
i_one_sec_tick  input  1  one-cycle pulse per second, from the one-second generator
sec  input  P_SEC_BIT  current seconds
min  input  P_MIN_BIT  current minutes
hour  input  P_HOUR_BIT  current hours
i_alarm_set  input  1  pulse: load i_set_hour/i_set_min into alarm registers
i_set_min  input  P_MIN_BIT  alarm minute to load
i_set_hour  input  P_HOUR_BIT  alarm hour to load
i_alarm_on  input  1  level: alarm armed when 1
i_stop  input  1  pulse: stop ringing/snooze
i_snooze  input  1  pulse: snooze while ringing
o_ring  output  1  ring drive
o_state  output  2  FSM state: 0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZE
o_alarm_min  output  P_MIN_BIT  stored alarm minute
o_alarm_hour  output  P_HOUR_BIT  stored alarm hour

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; alarm_hour=0, alarm_min=0.
  - ring_cnt=0, snooze_cnt=0, match_d=0.
  - o_ring=0.
- en=0: every register holds, including state, counters, match_d and alarm registers. All inputs are ignored. Outputs reflect held registers.
- Alarm load: when en=1 and i_alarm_set=1, registers update on the next edge, but only if i_set_hour<24 and i_set_min<60. Otherwise the load is ignored. A load is allowed in any state and does not change state.
- Match detection:
  - match = (hour==alarm_hour) && (min==alarm_min). Seconds are ignored.
  - match_d <= match every enabled cycle, in all states.
  - rise = match && !match_d.
- FSM, evaluated only when en=1. Priority within a state follows the listed order.
  - IDLE:
    - i_alarm_on=1 -> ARMED.
    - Arming while match is already 1 does not ring; a fresh rise is required.
  - ARMED:
    - i_alarm_on=0 -> IDLE.
    - Else rise -> RINGING with ring_cnt=0.
    - The state register updates at the edge after the cycle rise is seen.
  - RINGING:
    - i_alarm_on=0 -> IDLE.
    - Else i_stop -> ARMED.
    - Else i_snooze -> SNOOZE with snooze_cnt=P_SNOOZE_SEC.
    - Else on i_one_sec_tick: if ring_cnt==P_RING_SEC-1 -> ARMED (timeout), otherwise ring_cnt+1.
  - SNOOZE:
    - i_alarm_on=0 -> IDLE.
    - Else i_stop -> ARMED.
    - Else on i_one_sec_tick: if snooze_cnt==1 -> RINGING with ring_cnt=0, otherwise snooze_cnt-1.
    - i_snooze is ignored in SNOOZE.
- Simultaneous events: i_stop beats timeout and snooze in the same cycle; i_alarm_on=0 beats everything.
- Counter widths:
  - ring_cnt: $clog2(P_RING_SEC)+1 bits.
  - snooze_cnt: $clog2(P_SNOOZE_SEC+1) bits.
  - Neither counter ever wraps.
- Output mapping:
  - o_ring = (state==RINGING), registered via the state register. Latency is 1 clk from rise to o_ring=1.
  - o_state mirrors the state register.

Optional Feature:
ALARM_BLINK_EN
- Defined:
  - o_ring is gated by a blink flop.
  - The flop is set to 1 on entry to RINGING and toggles on each i_one_sec_tick while RINGING.
  - The flop is cleared outside RINGING.
  - o_ring = (state==RINGING) && blink.
- Undefined: o_ring is steady high throughout RINGING and no blink flop exists.

Test Plan:
- Reset/load:
  - Stimulus: assert reset=0 mid-RINGING.
  - Response: o_ring=0 and o_state=0 immediately (async); o_alarm_hour/min=0.
  - Then load 7:30 -> o_alarm_hour=7, o_alarm_min=30.
  - Then load 25:10 -> registers stay 7:30.
- Trigger:
  - Stimulus: alarm 7:30, i_alarm_on=1, clock steps from 7:29:59 to 7:30:00.
  - Response: o_state=2 and o_ring=1 one clk after min becomes 30.
  - Arming at 7:30:20 instead of before 7:30 -> no ring.
- Timeout:
  - Stimulus: ringing with P_RING_SEC=60, no buttons pressed.
  - Response: 60 ticks later o_state=1 and o_ring=0.
  - No retrigger during the remainder of minute 7:30.
- Snooze:
  - Stimulus: i_snooze pulse while ringing.
  - Response: o_state=3.
  - After exactly 300 ticks -> o_state=2 and o_ring=1.
  - i_stop during snooze -> o_state=1.
- Priority/en:
  - Stimulus: i_stop and i_snooze on the same cycle as the 60th tick.
  - Response: o_state=1.
  - i_alarm_on=0 together with i_stop -> o_state=0.
  - With en=0 held for 100 ticks during RINGING, state and ring_cnt are unchanged.
- Blink (ALARM_BLINK_EN defined):
  - Stimulus: enter RINGING.
  - Response: o_ring is 1, then 0 after the 1st tick, then 1 after the 2nd tick.
  - Without the macro, o_ring stays 1 across the same ticks.
